// File: rtl/agu_pkg.sv
// Shared encodings, FSM states and default widths for the address generation unit.
package agu_pkg;

  localparam int AGU_AW   = 8;
  localparam int AGU_NPTR = 4;
  localparam int AGU_NFWD = 2;

  localparam logic [1:0] AGU_PC_OD   = 2'b00;
  localparam logic [1:0] AGU_PTR     = 2'b01;
  localparam logic [1:0] AGU_PTR_OFS = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    STALL = 2'd2
  } agu_state_t;

endpackage

// File: rtl/agu_fwd_sel.sv
// Priority forwarding mux: the youngest stage (lowest index) that
// writes the requested pointer supplies its value.
module agu_fwd_sel
  import agu_pkg::*;
#(
  parameter int NFWD = AGU_NFWD,
  parameter int AW   = AGU_AW,
  parameter int PW   = 2
) (
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD*PW-1:0] fwd_idx,
  input  logic [NFWD*AW-1:0] fwd_data,
  input  logic [PW-1:0]      idx,
  output logic [AW-1:0]      val,
  output logic               hit
);

  always_comb begin
    val = '0;
    hit = 1'b0;
    // oldest first, so younger matches overwrite
    for (int s = NFWD - 1; s >= 0; s--) begin
      if (fwd_valid[s] && fwd_idx[s*PW +: PW] == idx) begin
        val = fwd_data[s*AW +: AW];
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/agu_fwd.sv
// Effective-address unit with operand forwarding, load-hazard stall and
// registered valid/ready output. Optional stall counter: AGU_STALL_CNT_EN.
module agu_fwd
  import agu_pkg::*;
#(
  parameter int AW   = AGU_AW,
  parameter int NPTR = AGU_NPTR,
  parameter int NFWD = AGU_NFWD,
  parameter int PW   = $clog2(NPTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_mode,
  input  logic [PW-1:0]      req_ptr,
  input  logic [AW-1:0]      req_ofs,
  input  logic [AW-1:0]      req_pc,
  input  logic [NPTR*AW-1:0] ptr_val,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD*PW-1:0] fwd_idx,
  input  logic [NFWD*AW-1:0] fwd_data,
  input  logic               pend_valid,
  input  logic [PW-1:0]      pend_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AW-1:0]      out_addr,
  output logic               out_fwd,
  output logic [15:0]        stall_cnt
);

  agu_state_t state, state_nxt;

  logic [AW-1:0] ptr_sel;
  logic [AW-1:0] fwd_val;
  logic [AW-1:0] base;
  logic [AW-1:0] addr;
  logic          hit;
  logic          use_fwd;
  logic          hazard;
  logic          accept;

  always_comb begin
    ptr_sel = '0;
    for (int i = 0; i < NPTR; i++) begin
      if (req_ptr == PW'(i)) ptr_sel = ptr_val[i*AW +: AW];
    end
  end

  agu_fwd_sel #(
    .NFWD(NFWD),
    .AW  (AW),
    .PW  (PW)
  ) u_sel (
    .fwd_valid(fwd_valid),
    .fwd_idx  (fwd_idx),
    .fwd_data (fwd_data),
    .idx      (req_ptr),
    .val      (fwd_val),
    .hit      (hit)
  );

  assign base = hit ? fwd_val : ptr_sel;

  always_comb begin
    addr    = base;
    use_fwd = hit;
    unique case (req_mode)
      AGU_PC_OD: begin
        addr    = req_pc - AW'(1);
        use_fwd = 1'b0;
      end
      AGU_PTR_OFS: addr = base + req_ofs;
      default: ;
    endcase
  end

  // a matching forward does not resolve a pending load
  assign hazard = req_valid && req_mode != AGU_PC_OD &&
                  pend_valid && pend_idx == req_ptr;

  assign out_valid = (state == HOLD);
  assign req_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    if (flush)                       state_nxt = IDLE;
    else if (accept)                 state_nxt = HOLD;
    else if (out_valid && !out_ready) state_nxt = HOLD;
    else if (hazard)                 state_nxt = STALL;
    else                             state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      out_addr <= '0;
      out_fwd  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_addr <= addr;
        out_fwd  <= use_fwd;
      end
    end
  end

`ifdef AGU_STALL_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == STALL && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign stall_cnt = cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_agu_fwd.sv
// Scoreboard bench for agu_fwd: directed cases, then random traffic
// against a behavioural address model.
module tb_agu_fwd;

  localparam int AW = 8, NPTR = 4, NFWD = 2, PW = 2;

  logic clk = 0, rst = 1, flush = 0;
  logic req_valid = 0, req_ready;
  logic [1:0] req_mode = 0;
  logic [PW-1:0] req_ptr = 0;
  logic [AW-1:0] req_ofs = 0, req_pc = 0;
  logic [NPTR*AW-1:0] ptr_val = 0;
  logic [NFWD-1:0] fwd_valid = 0;
  logic [NFWD*PW-1:0] fwd_idx = 0;
  logic [NFWD*AW-1:0] fwd_data = 0;
  logic pend_valid = 0;
  logic [PW-1:0] pend_idx = 0;
  logic out_valid, out_ready = 0, out_fwd;
  logic [AW-1:0] out_addr;
  logic [15:0] stall_cnt;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic fwd;
  } exp_t;
  exp_t q[$];
  logic mv = 0;

  agu_fwd dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_ptr(req_ptr),
    .req_ofs(req_ofs), .req_pc(req_pc),
    .ptr_val(ptr_val), .fwd_valid(fwd_valid),
    .fwd_idx(fwd_idx), .fwd_data(fwd_data),
    .pend_valid(pend_valid), .pend_idx(pend_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_fwd(out_fwd),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // effective address computed straight from the addressing rules
  function automatic exp_t ref_addr();
    exp_t e;
    logic [AW-1:0] b;
    bit found = 0;
    b = ptr_val[int'(req_ptr)*AW +: AW];
    for (int s = 0; s < NFWD; s++)
      if (!found && fwd_valid[s] && fwd_idx[s*PW +: PW] == req_ptr) begin
        b = fwd_data[s*AW +: AW];
        found = 1;
      end
    if (req_mode == 2'b00) begin
      e.addr = AW'((int'(req_pc) + 255) % 256);
      e.fwd = 0;
    end else begin
      e.addr = (req_mode == 2'b10) ? AW'((int'(b) + int'(req_ofs)) % 256) : b;
      e.fwd = found;
    end
    return e;
  endfunction

  task automatic model_step();
    bit hz, rdy, acc;
    chk("out_valid", 32'(out_valid), 32'(mv));
    hz = req_valid && req_mode != 2'b00 && pend_valid && pend_idx == req_ptr;
    rdy = !hz && (!mv || out_ready) && !flush;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    acc = req_valid && rdy;
    if (acc) q.push_back(ref_addr());
    if (flush) mv = 0;
    else if (acc) mv = 1;
    else if (out_ready) mv = 0;
  endtask

  // monitor: compares the presented output with the queue head
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("out_unexpected", 32'(out_addr), 32'hFFFF_FFFF);
      end else begin
        chk("out_addr", 32'(out_addr), 32'(q[0].addr));
        chk("out_fwd", 32'(out_fwd), 32'(q[0].fwd));
        if (out_ready || flush) void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(logic v, logic [1:0] m, logic [PW-1:0] p,
                         logic [AW-1:0] o, logic [AW-1:0] pc);
    req_valid = v; req_mode = m; req_ptr = p; req_ofs = o; req_pc = pc;
  endtask

  initial begin
    logic [15:0] exp_stall;
    repeat (2) tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_addr", 32'(out_addr), 0);
    chk("rst_fwd", 32'(out_fwd), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    rst = 0;
    tick();

    ptr_val = {8'h33, 8'h22, 8'h40, 8'h11};
    out_ready = 1;
    set_req(1, 2'b01, 1, 0, 0);
    tick();
    chk("ptr_addr", 32'(out_addr), 32'h40);
    chk("ptr_fwd", 32'(out_fwd), 0);
    fwd_valid = 2'b11;
    fwd_idx = {2'd1, 2'd1};
    fwd_data = {8'hB0, 8'hA0};
    tick();
    chk("prio_addr", 32'(out_addr), 32'hA0);
    chk("prio_fwd", 32'(out_fwd), 1);
    fwd_valid = 0;
    ptr_val[15:8] = 8'hF0;
    set_req(1, 2'b10, 1, 8'h20, 0);
    tick();
    chk("ofs_wrap", 32'(out_addr), 32'h10);
    set_req(1, 2'b00, 0, 0, 8'h00);
    tick();
    chk("pc_wrap", 32'(out_addr), 32'hFF);
    set_req(0, 0, 0, 0, 0);
    tick();

    pend_valid = 1; pend_idx = 2;
    set_req(1, 2'b01, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("haz_ready", 32'(req_ready), 0);
      tick();
    end
    pend_valid = 0;
    #1 chk("haz_clear", 32'(req_ready), 1);
    tick();
    chk("haz_accept", 32'(out_valid), 1);
`ifdef AGU_STALL_CNT_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd0;
`endif
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));

    out_ready = 0;
    set_req(1, 2'b01, 3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_ready", 32'(req_ready), 0);
      tick();
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_req(1, 2'(i % 3), PW'(i), AW'(8'h11 * i), AW'(8'h30 + i));
      #1 chk("b2b_ready", 32'(req_ready), 1);
      tick();
    end
    out_ready = 0;
    flush = 1;
    #1 chk("flush_ready", 32'(req_ready), 0);
    tick();
    flush = 0;
    chk("flush_valid", 32'(out_valid), 0);

    set_req(1, 2'b01, 0, 0, 0);
    tick();
    set_req(0, 0, 0, 0, 0);
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_addr", 32'(out_addr), 0);
    chk("arst_fwd", 32'(out_fwd), 0);
    chk("arst_stall", 32'(stall_cnt), 0);
    q.delete();
    mv = 0;
    tick();
    rst = 0;
    tick();

    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(3) != 0);
      req_mode = 2'($urandom);
      req_ptr = PW'($urandom);
      req_ofs = AW'($urandom);
      req_pc = AW'($urandom);
      ptr_val = ($urandom);
      fwd_valid = NFWD'($urandom);
      fwd_idx = (NFWD*PW)'($urandom);
      fwd_data = (NFWD*AW)'($urandom);
      pend_valid = ($urandom_range(3) == 0);
      pend_idx = PW'($urandom);
      out_ready = ($urandom_range(3) != 0);
      flush = ($urandom_range(19) == 0);
      tick();
    end

    set_req(0, 0, 0, 0, 0);
    flush = 0; pend_valid = 0; out_ready = 1;
    repeat (4) tick();
    chk("drain_empty", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/agu_fwd.md
# agu_fwd

Parametrised address generation unit for the pipelined RISC core's memory-access stage. It selects an effective address from the PC (operand-fetch mode), a pointer register, or a pointer plus offset. It applies operand forwarding from a configurable number of downstream pipeline stages and stalls on unresolved load hazards. The result is registered behind a valid/ready handshake into the memory stage.

## Interface
Parameters:
- AW, 8: address/data width.
- NPTR, 4: number of pointer registers; index 0 is SP, 1 is R0, 2..NPTR-1 are RN.
- NFWD, 2: forwarding stages; stage 0 is youngest (ALU out buffer), stage NFWD-1 is oldest.
- PW, $clog2(NPTR): pointer index width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; synchronous.
- req_valid  in  1  address request present.
- req_ready  out  1  request accepted this cycle when both valid and ready are high.
- req_mode  in  2  00 PC_OD, 01 PTR, 10 PTR_OFS, 11 reserved (treated as PTR).
- req_ptr  in  PW  pointer index.
- req_ofs  in  AW  two's-complement offset for PTR_OFS.
- req_pc  in  AW  PC of the requesting instruction.
- ptr_val  in  NPTR*AW  architectural pointer values, flat; entry i is at [i*AW +: AW].
- fwd_valid  in  NFWD  stage s holds a pointer writeback.
- fwd_idx  in  NFWD*PW  destination pointer per stage.
- fwd_data  in  NFWD*AW  forwarded value per stage.
- pend_valid  in  1  a load to pointer pend_idx is in flight with no data yet.
- pend_idx  in  PW  destination of that load.
- out_valid  out  1  registered address valid.
- out_ready  in  1  memory stage accepts.
- out_addr  out  AW  effective address.
- out_fwd  out  1  a forwarded value was used.
- stall_cnt  out  16  saturating hazard-stall count (only with AGU_STALL_CNT_EN).

## Operation
- Base address:
  - PC_OD: req_pc - 1, modulo 2^AW.
  - PTR / PTR_OFS: the pointer value, forwarded if a match exists.
- Forward select: the lowest s with fwd_valid[s] and fwd_idx[s]==req_ptr wins. If no stage matches, ptr_val[req_ptr] is used.
- PTR_OFS: base + req_ofs, modulo 2^AW; the carry is discarded.
- Hazard: req_valid && mode != PC_OD && pend_valid && pend_idx==req_ptr. A PC_OD request never hazards.
- A forward match on the same index as pend_idx does not clear the hazard; pend_valid must drop.
- req_ready = !hazard && (!out_valid || out_ready) && !flush.
- FSM states:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
  - STALL: a request is waiting on a hazard.
- Transitions:
  - IDLE→HOLD on accept.
  - IDLE→STALL on hazard.
  - STALL→HOLD on accept once the hazard clears.
  - HOLD→HOLD on accept while out_ready=1, or while out_ready=0 (the output is held stable).
  - HOLD→IDLE on out_ready with no accept.
  - HOLD→STALL on out_ready while a hazard is present.
- flush: next state IDLE, out_valid=0; no request is accepted that cycle.
- While out_valid && !out_ready, out_addr and out_fwd stay stable.

## Timing
- Reset values: out_valid=0, out_addr=0, out_fwd=0, stall_cnt=0, FSM=IDLE.
- Latency: one cycle, accept to out_valid. Full throughput of one address per cycle when out_ready stays high.
- Forwarding and hazard checks are combinational on the accept cycle; request inputs are sampled only at accept.
- req_ready is combinational from out_ready, pend_*, req_* and flush. There is no path from out_ready to out_valid within a cycle.
- Reset asserted mid-operation: outputs return to reset values immediately; an in-flight address is dropped.

## Configuration
- AGU_STALL_CNT_EN defined:
  - stall_cnt increments each cycle the FSM is in STALL.
  - Saturates at 16'hFFFF.
  - Clears only on rst; flush does not clear it.
- AGU_STALL_CNT_EN undefined: stall_cnt is tied to 0 and no counter flops are built.

## Structure
- Shared package agu_pkg holds:
  - the mode encodings AGU_PC_OD, AGU_PTR, AGU_PTR_OFS;
  - the FSM state enum (IDLE, HOLD, STALL);
  - the default widths.
- Sub-module agu_fwd_sel: combinational priority forwarding mux, parametrised by NFWD/AW/PW. It outputs the selected value and a hit flag.

## Test plan
- Reset, then PTR request with req_ptr=1 and ptr_val[1]=8'h40, no forwards, out_ready=1 -> next cycle out_valid=1, out_addr=8'h40, out_fwd=0.
- Forward priority: fwd_valid=2'b11, both stages idx=1, data 8'hA0 (stage 0) and 8'hB0 (stage 1) -> out_addr=8'hA0, out_fwd=1.
- PTR_OFS wrap: ptr_val=8'hF0, req_ofs=8'h20 -> out_addr=8'h10. PC_OD with req_pc=8'h00 -> out_addr=8'hFF.
- Hazard: pend_valid=1, pend_idx=2, req_ptr=2 for 3 cycles -> req_ready=0, FSM in STALL for 3 cycles, stall_cnt=3 (macro on). pend_valid drops -> accepted next cycle.
- Backpressure: out_ready=0 for 4 cycles with req_valid held -> out_addr stable, req_ready=0; out_ready=1 -> back-to-back accepts at one per cycle.
- flush with out_valid=1 and req_valid=1 -> next cycle out_valid=0, request not accepted.
- rst pulse mid-HOLD -> all outputs 0 asynchronously.
